// File: rtl/ov7620_pkg.sv
// Shared constants and capture state encoding for the OV7620 frame path.
// The SRAM frame-buffer controller imports the same frame geometry so its
// read scan walks exactly the addresses written by ov7620_frame_capture.
package ov7620_pkg;

    localparam int CAM_H_PIX       = 640;
    localparam int CAM_V_LINES     = 240;
    localparam int CAM_ADDR_W      = 18;
    localparam int CAM_SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_VS,
        ST_WAIT_VE,
        ST_WAIT_LINE,
        ST_LINE,
        ST_DONE
    } cap_state_t;

endpackage

// File: rtl/ov7620_frame_capture_cam_sync_edge.sv
// Single-bit synchroniser chain with rise/fall detection on the synchronised
// level. Every camera control input goes through one of these so all of them
// see the same delay and keep their relative alignment.
//   clk   : system clock
//   rst_n : synchronous active-low reset, clears chain and edge history
//   din   : asynchronous input
//   dout  : synchronised level (STAGES cycles behind din)
//   rise  : dout went 0->1 this cycle
//   fall  : dout went 1->0 this cycle
module cam_sync_edge
    import ov7620_pkg::*;
#(
    parameter int STAGES = CAM_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain_q, chain_d;
    logic              prev_q, prev_d;

    always_comb begin
        chain_d = {chain_q[STAGES-2:0], din};
        prev_d  = chain_q[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain_q <= '0;
            prev_q  <= 1'b0;
        end else begin
            chain_q <= chain_d;
            prev_q  <= prev_d;
        end
    end

    assign dout = chain_q[STAGES-1];
    assign rise = dout & ~prev_q;
    assign fall = ~dout & prev_q;

endmodule

// File: rtl/ov7620_frame_capture.sv
// Captures one OV7620 Y frame on request and turns it into a stream of
// linear-address pixel writes for the SRAM frame-buffer controller.
//   CLK/RSTn          : system clock, synchronous active-low reset
//   CAM_PCLK/VSYNC/HREF/Y : camera bus, oversampled by CLK (>= 4x PCLK)
//   Start             : one-cycle capture request (ignored while Busy)
//   Busy              : capture in progress, drops with Frame_Done
//   Frame_Done        : one-cycle pulse when the last line has ended
//   Wr_En/Wr_Addr/Wr_Data : one write strobe per stored pixel
//   Line_Cnt          : lines completed in the current/last frame
//   Short_Line_Err    : sticky, a line ended before H_PIX pixels
//   Frame_Abort_Err   : sticky, VSYNC arrived before V_LINES lines
module ov7620_frame_capture
    import ov7620_pkg::*;
#(
    parameter int H_PIX       = CAM_H_PIX,
    parameter int V_LINES     = CAM_V_LINES,
    parameter int ADDR_W      = CAM_ADDR_W,
    parameter int SYNC_STAGES = CAM_SYNC_STAGES
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              CAM_PCLK,
    input  logic              CAM_VSYNC,
    input  logic              CAM_HREF,
    input  logic [7:0]        CAM_Y,
    input  logic              Start,
    output logic              Busy,
    output logic              Frame_Done,
    output logic              Wr_En,
    output logic [ADDR_W-1:0] Wr_Addr,
    output logic [7:0]        Wr_Data,
    output logic [8:0]        Line_Cnt,
    output logic              Short_Line_Err,
    output logic              Frame_Abort_Err
);

    localparam int                COL_W  = $clog2(H_PIX + 1);
    localparam logic [COL_W-1:0]  H_LIM  = COL_W'(H_PIX);
    localparam logic [8:0]        V_LIM  = 9'(V_LINES);
    localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_PIX);

    // ---- synchroniser stage: control bits and Y share the same depth ----
    logic pix_stb, pclk_lvl_unused, pclk_fall_unused;
    logic vs_rise, vs_fall, vs_lvl_unused;
    logic href_sync, hr_fall, hr_rise_unused;

    cam_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_pclk (
        .clk(CLK), .rst_n(RSTn), .din(CAM_PCLK),
        .dout(pclk_lvl_unused), .rise(pix_stb), .fall(pclk_fall_unused)
    );
    cam_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_vsync (
        .clk(CLK), .rst_n(RSTn), .din(CAM_VSYNC),
        .dout(vs_lvl_unused), .rise(vs_rise), .fall(vs_fall)
    );
    cam_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_href (
        .clk(CLK), .rst_n(RSTn), .din(CAM_HREF),
        .dout(href_sync), .rise(hr_rise_unused), .fall(hr_fall)
    );

    logic [SYNC_STAGES-1:0][7:0] y_q, y_d;
    logic [7:0]                  y_sync;

    always_comb y_d = {y_q[SYNC_STAGES-2:0], CAM_Y};
    assign y_sync = y_q[SYNC_STAGES-1];

    // ---- capture FSM / write stage ----
    cap_state_t        state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d, col_n;
    logic [8:0]        line_q, line_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              short_q, short_d;
    logic              abort_q, abort_d;
    logic              pix_ok;

    // A strobe coinciding with HREF falling still belongs to the line.
    assign pix_ok = pix_stb & (href_sync | hr_fall);

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        col_n     = col_q;
        line_d    = line_q;
        base_d    = base_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        short_d   = short_q;
        abort_d   = abort_q;

        unique case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d = ST_WAIT_VS;
                    col_d   = '0;
                    line_d  = '0;
                    base_d  = '0;
                    short_d = 1'b0;
                    abort_d = 1'b0;
                end
            end
            ST_WAIT_VS: begin
                if (vs_rise) state_d = ST_WAIT_VE;
            end
            ST_WAIT_VE: begin
                if (vs_fall) begin
                    state_d = ST_WAIT_LINE;
                    col_d   = '0;
                    line_d  = '0;
                    base_d  = '0;
                end
            end
            ST_WAIT_LINE, ST_LINE: begin
                if (vs_rise) begin
                    // Early VSYNC: restart on the frame that is beginning now.
                    state_d = ST_WAIT_VE;
                    abort_d = 1'b1;
                    col_d   = '0;
                    line_d  = '0;
                    base_d  = '0;
                end else if (state_q == ST_LINE || (pix_stb && href_sync)) begin
                    state_d = ST_LINE;
                    if (pix_ok && col_q < H_LIM) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = base_q + ADDR_W'(col_q);
                        wr_data_d = y_sync;
                        col_n     = col_q + 1'b1;
                    end
                    col_d = col_n;
                    if (state_q == ST_LINE && hr_fall) begin
                        if (col_n < H_LIM) short_d = 1'b1;
                        base_d  = base_q + H_STEP;
                        line_d  = line_q + 9'd1;
                        col_d   = '0;
                        state_d = (line_q + 9'd1 == V_LIM) ? ST_DONE : ST_WAIT_LINE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            y_q       <= '0;
            state_q   <= ST_IDLE;
            col_q     <= '0;
            line_q    <= '0;
            base_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            short_q   <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            y_q       <= y_d;
            state_q   <= state_d;
            col_q     <= col_d;
            line_q    <= line_d;
            base_q    <= base_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            short_q   <= short_d;
            abort_q   <= abort_d;
        end
    end

    // ---- output stage ----
    assign Busy            = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign Frame_Done      = (state_q == ST_DONE);
    assign Wr_En           = wr_en_q;
    assign Wr_Addr         = wr_addr_q;
    assign Wr_Data         = wr_data_q;
    assign Line_Cnt        = line_q;
    assign Short_Line_Err  = short_q;
    assign Frame_Abort_Err = abort_q;

endmodule

// File: tb/tb_ov7620_frame_capture.sv
// Bench for ov7620_frame_capture on a reduced 16x6 frame. A camera model
// drives PCLK = CLK/8; every pixel that should be stored is queued as
// (line*H + col, Y) before it is sent, and a monitor matches each write
// strobe against that queue in order.
`timescale 1ns/1ps
module tb_ov7620_frame_capture;

    localparam int H  = 16;
    localparam int V  = 6;
    localparam int AW = 10;
    localparam int S  = 2;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          cam_pclk = 1'b0, cam_vsync = 1'b0, cam_href = 1'b0;
    logic [7:0]    cam_y = 8'h00;
    logic          start = 1'b0;
    logic          busy, frame_done, wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data, last_data;
    logic [8:0]    line_cnt;
    logic          short_err, abort_err;

    int n_checks = 0, n_errors = 0;
    int wr_cnt = 0, done_cnt = 0;
    int exp_addr[$];
    int exp_data[$];
    int line_len[8];
    bit y_ramp = 1'b1;

    always #5 clk = ~clk;

    ov7620_frame_capture #(
        .H_PIX(H), .V_LINES(V), .ADDR_W(AW), .SYNC_STAGES(S)
    ) dut (
        .CLK(clk), .RSTn(rstn),
        .CAM_PCLK(cam_pclk), .CAM_VSYNC(cam_vsync), .CAM_HREF(cam_href), .CAM_Y(cam_y),
        .Start(start), .Busy(busy), .Frame_Done(frame_done),
        .Wr_En(wr_en), .Wr_Addr(wr_addr), .Wr_Data(wr_data),
        .Line_Cnt(line_cnt), .Short_Line_Err(short_err), .Frame_Abort_Err(abort_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Monitor: every write must be the next queued pixel.
    always @(negedge clk) begin
        if (wr_en) begin
            wr_cnt++;
            last_data = wr_data;
            if (exp_addr.size() == 0) begin
                chk("unexpected_wr", 32'(wr_addr), 32'hFFFF_FFFF);
            end else begin
                chk("wr_addr", 32'(wr_addr), 32'(exp_addr.pop_front()));
                chk("wr_data", 32'(wr_data), 32'(exp_data.pop_front()));
            end
        end
        if (frame_done) begin
            done_cnt++;
            chk("busy_at_done", 32'(busy), 0);
        end
    end

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pclk_cycle(input logic [7:0] y, input logic href);
        cam_y    = y;
        cam_href = href;
        cam_pclk = 1'b0;
        wait_clk(4);
        cam_pclk = 1'b1;
        wait_clk(4);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        wait_clk(1);
        start = 1'b0;
    endtask

    task automatic vsync_pulse();
        cam_vsync = 1'b1;
        repeat (3) pclk_cycle(8'h00, 1'b0);
        cam_vsync = 1'b0;
        repeat (3) pclk_cycle(8'h00, 1'b0);
    endtask

    // One pixel of line l, column c; queued if the capture should store it.
    task automatic send_pix(input int l, input int c, input bit do_exp);
        logic [7:0] y;
        y = y_ramp ? 8'((c + l) & 8'hFF) : 8'($urandom_range(0, 255));
        if (do_exp && l < V && c < H) begin
            exp_addr.push_back(l * H + c);
            exp_data.push_back(int'(y));
        end
        pclk_cycle(y, 1'b1);
    endtask

    task automatic send_frame(input int nlines, input bit do_exp, input int start_line);
        vsync_pulse();
        for (int l = 0; l < nlines; l++) begin
            if (l == start_line) pulse_start();
            for (int c = 0; c < line_len[l]; c++) send_pix(l, c, do_exp);
            repeat (2) pclk_cycle(8'h00, 1'b0);
        end
    endtask

    task automatic set_lens(input int lo, input int hi);
        for (int i = 0; i < 8; i++) line_len[i] = $urandom_range(lo, hi);
    endtask

    initial begin
        int n;
        // Reset state
        wait_clk(3);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(frame_done), 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_line_cnt", 32'(line_cnt), 0);
        chk("rst_short", 32'(short_err), 0);
        chk("rst_abort", 32'(abort_err), 0);
        rstn = 1'b1;
        wait_clk(2);

        // Full ramp frame; a second Start mid-frame is ignored
        set_lens(H, H);
        y_ramp = 1'b1;
        pulse_start();
        chk("busy_after_start", 32'(busy), 1);
        send_frame(V, 1'b1, 2);
        wait_clk(4);
        chk("full_done_cnt", 32'(done_cnt), 1);
        chk("full_wr_cnt", 32'(wr_cnt), H * V);
        chk("full_last_data", 32'(last_data), (H - 1 + V - 1) & 255);
        chk("full_busy", 32'(busy), 0);
        chk("full_line_cnt", 32'(line_cnt), V);
        chk("full_short", 32'(short_err), 0);
        chk("full_abort", 32'(abort_err), 0);
        chk("full_pending", 32'(exp_addr.size()), 0);

        // Start arrives mid-frame: nothing until the next frame
        y_ramp = 1'b0;
        send_frame(V, 1'b0, 3);
        chk("mid_no_writes", 32'(wr_cnt), H * V);
        chk("mid_busy", 32'(busy), 1);
        set_lens(H, H + 3);
        send_frame(V, 1'b1, -1);
        wait_clk(4);
        chk("mid_done_cnt", 32'(done_cnt), 2);
        chk("mid_short", 32'(short_err), 0);
        chk("mid_pending", 32'(exp_addr.size()), 0);

        // Long line then short line
        set_lens(H, H);
        line_len[0] = H + 4;
        line_len[1] = H - 4;
        pulse_start();
        send_frame(V, 1'b1, -1);
        wait_clk(4);
        chk("ls_short", 32'(short_err), 1);
        chk("ls_abort", 32'(abort_err), 0);
        chk("ls_done_cnt", 32'(done_cnt), 3);
        chk("ls_pending", 32'(exp_addr.size()), 0);
        pulse_start();
        chk("start_clears_short", 32'(short_err), 0);
        chk("start_clears_lines", 32'(line_cnt), 0);

        // Early VSYNC after 3 lines, then a full frame from address 0
        set_lens(H, H);
        send_frame(3, 1'b1, -1);
        chk("ab_busy_partial", 32'(busy), 1);
        chk("ab_no_err_yet", 32'(abort_err), 0);
        send_frame(V, 1'b1, -1);
        wait_clk(4);
        chk("ab_abort", 32'(abort_err), 1);
        chk("ab_done_cnt", 32'(done_cnt), 4);
        chk("ab_busy", 32'(busy), 0);
        chk("ab_line_cnt", 32'(line_cnt), V);
        chk("ab_pending", 32'(exp_addr.size()), 0);

        // Isolated first pixel: latency and data
        pulse_start();
        vsync_pulse();
        cam_href = 1'b1;
        cam_y    = 8'hA5;
        cam_pclk = 1'b0;
        wait_clk(4);
        exp_addr.push_back(0);
        exp_data.push_back(8'hA5);
        cam_pclk = 1'b1;
        n = 0;
        while (n < 12 && wr_en !== 1'b1) begin
            wait_clk(1);
            n++;
        end
        chk("lat_wr_en", 32'(wr_en), 1);
        chk("lat_data", 32'(wr_data), 8'hA5);
        chk("lat_in_window", 32'(n >= S + 1 && n <= S + 3), 1);
        wait_clk(2);

        // Reset in the middle of line 2
        for (int c = 1; c < H; c++) send_pix(0, c, 1'b1);
        repeat (2) pclk_cycle(8'h00, 1'b0);
        for (int c = 0; c < H; c++) send_pix(1, c, 1'b1);
        repeat (2) pclk_cycle(8'h00, 1'b0);
        for (int c = 0; c < 7; c++) send_pix(2, c, 1'b1);
        chk("pre_rst_line_cnt", 32'(line_cnt), 2);
        rstn = 1'b0;
        wait_clk(1);
        chk("mr_wr_en", 32'(wr_en), 0);
        chk("mr_busy", 32'(busy), 0);
        chk("mr_done", 32'(frame_done), 0);
        chk("mr_wr_addr", 32'(wr_addr), 0);
        chk("mr_wr_data", 32'(wr_data), 0);
        chk("mr_line_cnt", 32'(line_cnt), 0);
        rstn = 1'b1;
        n = wr_cnt;
        for (int c = 7; c < H; c++) send_pix(2, c, 1'b0);
        repeat (2) pclk_cycle(8'h00, 1'b0);
        send_frame(V, 1'b0, -1);
        chk("mr_no_writes", 32'(wr_cnt - n), 0);
        chk("mr_idle", 32'(busy), 0);
        pulse_start();
        send_frame(V, 1'b1, -1);
        wait_clk(4);
        chk("mr_done_cnt", 32'(done_cnt), 5);
        chk("mr_pending", 32'(exp_addr.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ov7620_frame_capture.md
Name: ov7620_frame_capture

Overview:
- Upstream stage of the SRAM frame-buffer controller.
- Samples the OV7620 8-bit Y pixel bus (PCLK/HREF/VSYNC) in the system clock domain and captures exactly one frame on request.
- Emits one write strobe per pixel with a linear address (line*H_PIX + col) and data, for the SRAM controller's write phase.
- Reports frame completion and capture errors.

Parameters:
- H_PIX, 640, pixels stored per line; extra pixels in a line are dropped.
- V_LINES, 240, lines stored per frame.
- ADDR_W, 18, write address width; H_PIX*V_LINES must be <= 2^ADDR_W.
- SYNC_STAGES, 2, flop stages on every camera input (minimum 2).

Ports:
- CLK  in  1  system clock; must be >= 4x the camera PCLK frequency.
- RSTn  in  1  reset, synchronous, active-low.
- CAM_PCLK  in  1  camera pixel clock, treated as data and sampled by CLK.
- CAM_VSYNC  in  1  frame sync, active-high pulse before each frame.
- CAM_HREF  in  1  line valid, active-high.
- CAM_Y  in  8  luminance byte, valid on PCLK rising edge while HREF=1.
- Start  in  1  one-cycle request to capture the next full frame.
- Busy  out  1  high from an accepted Start until Frame_Done.
- Frame_Done  out  1  one-cycle pulse after the last pixel write of the frame.
- Wr_En  out  1  one-cycle write strobe per stored pixel; no backpressure.
- Wr_Addr  out  ADDR_W  linear pixel address.
- Wr_Data  out  8  pixel Y value.
- Line_Cnt  out  9  lines completed in the current frame.
- Short_Line_Err  out  1  sticky: a line ended with col < H_PIX.
- Frame_Abort_Err  out  1  sticky: VSYNC arrived before V_LINES lines were complete.

Behaviour:
- Reset (RSTn=0 at a CLK edge): state IDLE. All outputs 0. Counters and sync chains clear. Sticky errors clear; they also clear on an accepted Start.
- Synchroniser: CAM_PCLK, CAM_VSYNC, CAM_HREF and CAM_Y pass through identical SYNC_STAGES chains so their relative alignment is preserved.
  - pix_stb = synchronised PCLK 0->1 edge.
  - vs_rise and vs_fall, and hr_fall, are detected the same way on the synchronised VSYNC and HREF.
- States:
  - IDLE: Busy=0. Start -> WAIT_VS and Busy=1 on the next cycle.
  - WAIT_VS: wait for vs_rise -> WAIT_VE. A capture never begins mid-frame.
  - WAIT_VE: wait for vs_fall. Then clear col, line, and line_base=0 -> WAIT_LINE.
  - WAIT_LINE: pix_stb with synchronised HREF=1 -> LINE, and that pixel is processed as a LINE pixel in the same cycle.
  - LINE: each pix_stb with HREF=1 and col < H_PIX produces, on the next cycle:
    - Wr_En=1, Wr_Addr=line_base+col, Wr_Data = the synchronised Y sampled with that strobe;
    - then col increments.
    - Pixels with col >= H_PIX are silently dropped.
  - Line end: on hr_fall in LINE:
    - if col < H_PIX, set Short_Line_Err (unwritten addresses are skipped);
    - line_base += H_PIX, line += 1, col = 0;
    - if line reaches V_LINES -> DONE, otherwise -> WAIT_LINE.
  - DONE: Frame_Done=1 for exactly one cycle, Busy falls the same cycle, then -> IDLE.
- Latency: Wr_En fires exactly SYNC_STAGES+2 CLK cycles after the PCLK rising edge at the pin. This is fixed and holds ±1 cycle of sampling jitter.
- Address arithmetic:
  - line_base is an incremental adder; no multiplier.
  - Wr_Addr never exceeds H_PIX*V_LINES-1 and never wraps.
- Abort: vs_rise in WAIT_LINE or LINE sets Frame_Abort_Err, resets col/line/line_base, and goes to WAIT_VE, i.e. it restarts on that frame. Busy stays 1.
- Simultaneous events:
  - hr_fall and pix_stb in the same cycle: the pixel is processed first, then the line end.
  - vs_rise has priority over both.
- Start while Busy=1 is ignored.
- RSTn low mid-frame stops Wr_En on the next edge.
- Line_Cnt = line register, held until the next accepted Start.

Decomposition:
- Shared package ov7620_pkg holds:
  - the state encoding (IDLE, WAIT_VS, WAIT_VE, WAIT_LINE, LINE, DONE);
  - H_PIX/V_LINES defaults (640/240);
  - ADDR_W=18.
  The SRAM controller uses the same constants for its 640x240 read scan.
- One sub-module, cam_sync_edge: a parameterised synchroniser chain plus a rise/fall detector. It is instantiated for PCLK, VSYNC and HREF; Y uses a plain delay of equal depth.

Test Plan:
- Full frame: 640x240 model, PCLK=CLK/8, ramp Y=(col+line)&0xFF, Start pulse before VSYNC -> exactly 153600 Wr_En pulses, addresses 0..153599 in order, last Wr_Data=(639+239)&0xFF=0x6E, one Frame_Done, Busy low after, no errors.
- Mid-frame Start: Start asserted during line 100 -> no writes until the next VSYNC falling edge, then the first write is Wr_Addr=0.
- Long/short lines: line 0 has 700 pixels, line 1 has 600 -> line 0 writes only 0..639; line 1 writes 640..1239; line 2 starts at 1280; Short_Line_Err=1.
- Early VSYNC: VSYNC rises after 50 lines -> Frame_Abort_Err=1, Busy stays 1, the next frame writes from address 0, and Frame_Done follows its 240th line.
- Reset mid-line: RSTn=0 for 1 cycle at col 300 of line 10 -> Wr_En=0 next cycle, all outputs 0, state IDLE; no writes until a new Start plus VSYNC.
- Latency: single isolated PCLK edge with HREF=1, Y=0xA5 -> Wr_En exactly SYNC_STAGES+2 cycles later (±1) with Wr_Data=0xA5.
